iter_divider: RTL and testbench

//  Parametrised iterative integer divider for the RV32M DIV/DIVU/REM/REMU group; successor to the fixed 32-bit word types.

---
 rtl/iter_divider.sv | 170 +++++++++++++++++
 tb/tb_iter_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// =============================================================================
// iter_divider : iterative RISC-V M-extension divider, optional DIV_FAST_PATH_EN
// Rev 1.0
// =============================================================================
`default_nettype none

module iter_divider #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            annul_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN:0]    step_shift;
    logic [XLEN-1:0]  step_quo, step_rem;
    logic             quo_neg, rem_neg;
    logic [XLEN-1:0]  fix_quo, fix_rem;

    // quo_q doubles as the dividend shift register: quotient bits enter at the LSB
    always_comb begin
        step_quo   = quo_q;
        step_rem   = rem_q;
        step_shift = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_shift = {step_rem, step_quo[XLEN-1]};
            if (step_shift >= {1'b0, dvs_q}) begin
                step_rem = step_shift[XLEN-1:0] - dvs_q;
                step_quo = {step_quo[XLEN-2:0], 1'b1};
            end else begin
                step_rem = step_shift[XLEN-1:0];
                step_quo = {step_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Divide-by-zero leaves quotient all ones and remainder = |dividend|; sign fix-up keeps those correct
    assign quo_neg = ~op_q[0] & (dvd_neg_q ^ dvs_neg_q) & (dvs_q != '0);
    assign rem_neg = ~op_q[0] & dvd_neg_q;
    assign fix_quo = quo_neg ? -step_quo : step_quo;
    assign fix_rem = rem_neg ? -step_rem : step_rem;

`ifdef DIV_FAST_PATH_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic            fast_zero, fast_ovf;
    logic [XLEN-1:0] fast_result;
    assign fast_zero   = (divisor_i == '0);
    assign fast_ovf    = ~op_i[0] & (dividend_i == INT_MIN) & (divisor_i == '1);
    assign fast_result = fast_zero ? (op_i[1] ? dividend_i : '1)
                                   : (op_i[1] ? '0 : INT_MIN);
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    op_d    = op_i;
                    quo_d   = dividend_i;
                    dvs_d   = divisor_i;
                    rem_d   = '0;
                    state_d = S_PREP;
`ifdef DIV_FAST_PATH_EN
                    if (fast_zero || fast_ovf) begin
                        state_d  = S_DONE;
                        result_d = fast_result;
                    end
`endif
                end
            end
            S_PREP: begin
                dvd_neg_d = ~op_q[0] & quo_q[XLEN-1];
                dvs_neg_d = ~op_q[0] & dvs_q[XLEN-1];
                quo_d     = (~op_q[0] & quo_q[XLEN-1]) ? -quo_q : quo_q;
                dvs_d     = (~op_q[0] & dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
                rem_d     = '0;
                cnt_d     = CNT_START;
                state_d   = S_CALC;
            end
            S_CALC: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = op_q[1] ? fix_rem : fix_quo;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A flush abandons the op without touching the visible result
        if (annul_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign ready_o  = (state_q == S_DONE) & ~annul_i;
    assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// =============================================================================
// tb_iter_divider : directed vectors plus corner sequences for iter_divider
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_iter_divider;

`ifdef DIV_FAST_PATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, annul_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i, divisor_i, result_o;
    logic        busy_o, ready_o;

    logic        start64, annul64;
    logic [1:0]  op64;
    logic [63:0] dvd64, dvs64, res64;
    logic        busy64, ready64;

    always #5 clk = ~clk;

    iter_divider #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i),
        .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o)
    );

    iter_divider #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
        .clk(clk), .rst(rst), .start_i(start64), .op_i(op64),
        .dividend_i(dvd64), .divisor_i(dvs64), .annul_i(annul64),
        .busy_o(busy64), .ready_o(ready64), .result_o(res64)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Entered and left at posedge+1 with the DUT idle
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
        @(posedge clk); #1; start_i = 1'b0; #1;
        lat = 1;
        while (!ready_o && lat < 200) begin
            @(posedge clk); #2; lat++;
        end
        check({name, "_result"}, result_o, exp);
        check({name, "_latency"}, lat, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic run64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input string name);
        int lat;
        int exp_lat;
        logic [63:0] exp;
        exp     = ref64(op, a, b);
        exp_lat = (FAST_EN && is_fast64(op, a, b)) ? 1 : 18;
        start64 = 1'b1; op64 = op; dvd64 = a; dvs64 = b;
        @(posedge clk); #1; start64 = 1'b0; #1;
        lat = 1;
        while (!ready64 && lat < 200) begin
            @(posedge clk); #2; lat++;
        end
        check({name, "_result"}, res64, exp);
        check({name, "_latency"}, lat, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic watch_no_ready(input int cycles, input string name);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #2;
            if (ready_o) seen++;
        end
        check(name, seen, 0);
    endtask

    function automatic bit is_fast64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [63:0] ref64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        sa = a; sb = b;
        if (b == 64'd0) return op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) return op[1] ? 64'd0 : a;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'd0;
        dividend_i = '0; divisor_i = '0;
        start64 = 1'b0; annul64 = 1'b0; op64 = 2'd0; dvd64 = '0; dvs64 = '0;

        vecs.push_back('{2'd1, 32'd100,        32'd7,          32'd14,         1'b0, "divu_100_7"});
        vecs.push_back('{2'd3, 32'd100,        32'd7,          32'd2,          1'b0, "remu_100_7"});
        vecs.push_back('{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, "div_m7_2"});
        vecs.push_back('{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, "rem_m7_2"});
        vecs.push_back('{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, "rem_7_m2"});
        vecs.push_back('{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, "div_7_m2"});
        vecs.push_back('{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "div_5_0"});
        vecs.push_back('{2'd0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1, "div_m5_0"});
        vecs.push_back('{2'd3, 32'd5,          32'd0,          32'd5,          1'b1, "remu_5_0"});
        vecs.push_back('{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1, "rem_m5_0"});
        vecs.push_back('{2'd1, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b1, "divu_0_0"});
        vecs.push_back('{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "div_ovf"});
        vecs.push_back('{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, "rem_ovf"});
        vecs.push_back('{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, "divu_max_1"});
        vecs.push_back('{2'd1, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  1'b0, "divu_max_16"});
        vecs.push_back('{2'd0, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, "div_min_1"});
        vecs.push_back('{2'd3, 32'h8000_0000,  32'd3,          32'd2,          1'b0, "remu_min_3"});
        vecs.push_back('{2'd1, 32'd3,          32'd7,          32'd0,          1'b0, "divu_small"});

        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", busy_o, 1'b0);
        check("reset_ready", ready_o, 1'b0);
        check("reset_result", result_o, 32'd0);
        check("reset_busy64", busy64, 1'b0);
        @(posedge clk); #1; rst = 1'b0;

        foreach (vecs[i])
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                  (FAST_EN && vecs[i].fast) ? 1 : 34, vecs[i].name);

        // start pulse while busy must be dropped
        begin
            int lat;
            start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
            @(posedge clk); #1; start_i = 1'b0; #1;
            check("busy_after_start", busy_o, 1'b1);
            repeat (2) @(posedge clk);
            #1;
            start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
            @(posedge clk); #1; start_i = 1'b0; #1;
            lat = 4;
            while (!ready_o && lat < 200) begin
                @(posedge clk); #2; lat++;
            end
            check("ignored_start_result", result_o, 32'd14);
            check("ignored_start_latency", lat, 34);
            watch_no_ready(40, "ignored_start_no_ready");
            @(posedge clk); #1;
        end

        // annul in CALC at start+10
        start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd200; divisor_i = 32'd7;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1; annul_i = 1'b0; #1;
        check("annul_busy", busy_o, 1'b0);
        check("annul_ready", ready_o, 1'b0);
        check("annul_result_kept", result_o, 32'd14);
        @(posedge clk); #1;
        run32(2'd3, 32'd100, 32'd7, 32'd2, 34, "after_annul");

        // start and annul in the same idle cycle
        start_i = 1'b1; annul_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk); #1; start_i = 1'b0; annul_i = 1'b0; #1;
        check("start_annul_same_cycle", busy_o, 1'b0);
        @(posedge clk); #1;

        // annul during DONE suppresses ready_o
        start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        annul_i = 1'b1; #1;
        check("annul_done_busy", busy_o, 1'b1);
        check("annul_done_ready", ready_o, 1'b0);
        @(posedge clk); #1; annul_i = 1'b0; #1;
        check("annul_done_idle", busy_o, 1'b0);
        @(posedge clk); #1;

        // reset mid-operation
        start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; #1;
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_ready", ready_o, 1'b0);
        check("midrst_result", result_o, 32'd0);
        watch_no_ready(40, "midrst_no_ready");
        @(posedge clk); #1;

        // 64-bit, 4 bits per cycle, against the reference model
        run64(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, "d64_divu_max_3");
        run64(2'd0, -64'sd100, 64'd7, "d64_div_m100_7");
        run64(2'd2, -64'sd100, 64'd7, "d64_rem_m100_7");
        run64(2'd3, 64'h1234_5678_9ABC_DEF0, 64'd0, "d64_remu_by0");
        run64(2'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "d64_div_ovf");
        run64(2'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "d64_rem_ovf");
        for (int k = 0; k < 8; k++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 60);
            run64(2'($urandom_range(0, 3)), ra, rb, $sformatf("d64_rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
